// File: rtl/button_pulse_conditioner_if.sv
// Button conditioner signal bundle: raw button in, conditioned pulse and status out.
interface button_pulse_conditioner_if;
    logic ButtonIn;
    logic Pulse;
    logic Debounced;
    logic RepeatActive;

    modport master (
        output ButtonIn,
        input  Pulse,
        input  Debounced,
        input  RepeatActive
    );

    modport slave (
        input  ButtonIn,
        output Pulse,
        output Debounced,
        output RepeatActive
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// Synchronises and debounces a raw push-button and emits one-cycle enable pulses
// per qualified press, with optional auto-repeat while the button is held.
module button_pulse_conditioner #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 64,
    parameter int unsigned REPEAT_PERIOD = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic Clock,
    input  logic Reset,
    button_pulse_conditioner_if.slave btn
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_ON   = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    logic             meta_q;
    logic             sync_q;
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] timer_q,  timer_d;
    logic             pulse_q,  pulse_d;
    logic             deb_q,    deb_d;
    logic             rep_q,    rep_d;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn.ButtonIn;
            sync_q <= meta_q;
        end
    end

    // State, timer and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            deb_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            deb_q   <= deb_d;
            rep_q   <= rep_d;
        end
    end

    // Next-state, timer and output decode
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + CNT_W'(1);
        pulse_d = 1'b0;
        rep_d   = rep_q;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                rep_d   = 1'b0;
                if (sync_q) begin
                    state_d = PRESS_CHK;
                end
            end

            PRESS_CHK: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = PRESSED;
                    timer_d = '0;
                    pulse_d = 1'b1;
                end
            end

            PRESSED: begin
                // A release always wins over a coincident repeat expiry
                if (!sync_q) begin
                    state_d = RELEASE_CHK;
                    timer_d = '0;
                end else if (!REPEAT_ON) begin
                    timer_d = '0;
                end else if (!rep_q && (timer_q == DELAY_LAST)) begin
                    pulse_d = 1'b1;
                    rep_d   = 1'b1;
                    timer_d = '0;
                end else if (rep_q && (timer_q == PERIOD_LAST)) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                end
            end

            RELEASE_CHK: begin
                // A bounce back high restarts the repeat delay without a pulse
                if (sync_q) begin
                    state_d = PRESSED;
                    timer_d = '0;
                    rep_d   = 1'b0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    rep_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                rep_d   = 1'b0;
            end
        endcase

        deb_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    end

    assign btn.Pulse        = pulse_q;
    assign btn.Debounced    = deb_q;
    assign btn.RepeatActive = rep_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: expected pulse edges are queued as stimulus is driven and
// matched against observed Pulse cycles, for a repeat and a no-repeat instance.
module tb_button_pulse_conditioner;

    logic Clock  = 1'b0;
    logic Reset  = 1'b1;
    logic button = 1'b0;

    int cyc     = 0;
    int nchecks = 0;
    int nerrors = 0;

    int exp_rep[$];
    int exp_norep[$];

    button_pulse_conditioner_if bus_rep ();
    button_pulse_conditioner_if bus_norep ();

    assign bus_rep.ButtonIn   = button;
    assign bus_norep.ButtonIn = button;

    button_pulse_conditioner #(.REPEAT_EN(1)) dut_rep (
        .Clock (Clock),
        .Reset (Reset),
        .btn   (bus_rep.slave)
    );

    button_pulse_conditioner #(.REPEAT_EN(0)) dut_norep (
        .Clock (Clock),
        .Reset (Reset),
        .btn   (bus_norep.slave)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitors pop the scoreboard on every observed pulse cycle
    always @(negedge Clock) begin
        int e;
        if (bus_rep.Pulse === 1'b1) begin
            if (exp_rep.size() == 0) begin
                check("rep_unexpected_pulse", 32'(bus_rep.Pulse), 0);
            end else begin
                e = exp_rep.pop_front();
                check("rep_pulse_edge", cyc, e);
            end
        end
        if (bus_norep.Pulse === 1'b1) begin
            if (exp_norep.size() == 0) begin
                check("norep_unexpected_pulse", 32'(bus_norep.Pulse), 0);
            end else begin
                e = exp_norep.pop_front();
                check("norep_pulse_edge", cyc, e);
            end
        end
    end

    task automatic idle(input int n);
        button = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_rep_q_left"}, exp_rep.size(), 0);
        check({tag, "_norep_q_left"}, exp_norep.size(), 0);
    endtask

    task automatic check_deb(input string tag, input int exp);
        check({tag, "_rep_deb"}, 32'(bus_rep.Debounced), exp);
        check({tag, "_norep_deb"}, 32'(bus_norep.Debounced), exp);
    endtask

    // Clean press held for n sampled cycles, then released
    task automatic clean_press(input int n);
        int e0;
        int r;
        @(negedge Clock);
        e0 = cyc + 1;
        button = 1'b1;
        exp_norep.push_back(e0 + 18);
        for (int p = 18; p <= n + 1; p += (p == 18) ? 64 : 16) exp_rep.push_back(e0 + p);
        r = 0;
        while (r < n + 20) begin
            @(negedge Clock);
            r = cyc - e0;
            if (r == n - 1) button = 1'b0;
            if (r == 17) check_deb("press_pre", 0);
            if (r == 18) check_deb("press_edge", 1);
            if (r == 81 && n > 90) check("rep_pre_start", 32'(bus_rep.RepeatActive), 0);
            if (r == 82 && n > 90) begin
                check("rep_start", 32'(bus_rep.RepeatActive), 1);
                check("norep_never_repeat", 32'(bus_norep.RepeatActive), 0);
            end
            if (r == n + 17) begin
                check_deb("release_pre", 1);
                check("release_pre_rep", 32'(bus_rep.RepeatActive), (n + 1 >= 82) ? 1 : 0);
            end
            if (r == n + 18) begin
                check_deb("release_edge", 0);
                check("release_rep_clr", 32'(bus_rep.RepeatActive), 0);
            end
        end
        check_queues("clean");
    endtask

    // Contact bounce that never stays high long enough to qualify
    task automatic bounce();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int h = 0; h < 8; h++) begin
                @(negedge Clock);
                button = (h < 5);
                seen = seen | bus_rep.Debounced | bus_norep.Debounced;
            end
        end
        for (int h = 0; h < 25; h++) begin
            @(negedge Clock);
            button = 1'b0;
            seen = seen | bus_rep.Debounced | bus_norep.Debounced;
        end
        check("bounce_deb", 32'(seen), 0);
        check_queues("bounce");
    endtask

    // Short low glitch while repeating: delay restarts from re-entry
    task automatic glitch_press();
        int e0;
        int r;
        @(negedge Clock);
        e0 = cyc + 1;
        button = 1'b1;
        exp_norep.push_back(e0 + 18);
        exp_rep.push_back(e0 + 18);
        exp_rep.push_back(e0 + 82);
        exp_rep.push_back(e0 + 160);
        r = 0;
        while (r < 190) begin
            @(negedge Clock);
            r = cyc - e0;
            if (r == 89)  button = 1'b0;
            if (r == 93)  button = 1'b1;
            if (r == 169) button = 1'b0;
            if (r == 94)  check_deb("glitch_mid", 1);
            if (r == 95)  check("glitch_rep_pre", 32'(bus_rep.RepeatActive), 1);
            if (r == 96) begin
                check("glitch_rep_clr", 32'(bus_rep.RepeatActive), 0);
                check_deb("glitch_reentry", 1);
            end
            if (r == 159) check("glitch_rep_pre_restart", 32'(bus_rep.RepeatActive), 0);
            if (r == 160) check("glitch_rep_restart", 32'(bus_rep.RepeatActive), 1);
            if (r == 187) check_deb("glitch_release_pre", 1);
            if (r == 188) check_deb("glitch_release", 0);
        end
        check_queues("glitch");
    endtask

    // Reset pulse while repeating, button still held afterwards
    task automatic reset_mid_hold();
        int e0;
        int e1;
        int r;
        @(negedge Clock);
        e0 = cyc + 1;
        button = 1'b1;
        exp_norep.push_back(e0 + 18);
        exp_rep.push_back(e0 + 18);
        exp_rep.push_back(e0 + 82);
        while (cyc < e0 + 97) @(negedge Clock);
        @(posedge Clock);
        #1;
        check("pre_rst_pulse", 32'(bus_rep.Pulse), 1);
        check("pre_rst_rep", 32'(bus_rep.RepeatActive), 1);
        Reset = 1'b0;
        #1;
        check("rst_async_pulse", 32'(bus_rep.Pulse), 0);
        check("rst_async_rep", 32'(bus_rep.RepeatActive), 0);
        check_deb("rst_async", 0);
        repeat (3) @(negedge Clock);
        e1 = cyc + 1;
        Reset = 1'b1;
        exp_rep.push_back(e1 + 18);
        exp_norep.push_back(e1 + 18);
        r = 0;
        while (r < 20) begin
            @(negedge Clock);
            r = cyc - e1;
            if (r == 17) check_deb("post_rst_pre", 0);
            if (r == 18) check_deb("post_rst_press", 1);
        end
        idle(25);
        check_deb("post_rst_release", 0);
        check_queues("reset");
    endtask

    initial begin
        #1 Reset = 1'b0;
        #2;
        check("reset_pulse", 32'(bus_rep.Pulse), 0);
        check("reset_rep", 32'(bus_rep.RepeatActive), 0);
        check("reset_norep_pulse", 32'(bus_norep.Pulse), 0);
        check("reset_norep_rep", 32'(bus_norep.RepeatActive), 0);
        check_deb("reset", 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        idle(5);

        clean_press(40);
        idle(10);
        bounce();
        clean_press(40);
        idle(10);
        clean_press(200);
        idle(10);
        glitch_press();
        idle(10);
        reset_mid_hold();
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
